qspi_pin_arbiter: RTL and testbench

- Shares the single external QSPI flash pin set (sck, cs, dq[3:0] with output enables) between two requesters: requester 0 is the SoC SPI flash controller, requester 1 is the debug/boot-loader bridge.
- Sits between the requesters and the IOBUF tristate layer in the top level.
- Grants ownership per transaction using round-robin.
- Guarantees cs is deasserted and all dq are released for a turnaround gap between owners.

---
 rtl/qspi_arb_pkg.sv | 17 +
 rtl/qspi_pin_mux.sv | 38 +++
 rtl/qspi_pin_arbiter.sv | 130 +++++++++++++
 tb/tb_qspi_pin_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_arb_pkg.sv
// Shared types and pad idle levels for the QSPI pin arbiter.
package qspi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        TURN = 2'd3
    } arb_state_t;

    typedef logic owner_t;

    localparam logic       CS_IDLE    = 1'b1;
    localparam logic       SCK_IDLE   = 1'b0;
    localparam logic [3:0] DQ_OE_IDLE = 4'h0;

endpackage

// File: rtl/qspi_pin_mux.sv
// Combinational pad selector: drives the pins from the owning requester
// and routes the pad input data back to that requester only.
module qspi_pin_mux
    import qspi_arb_pkg::*;
(
    input  owner_t     owner,
    input  logic       valid,
    input  logic [1:0] r_sck,
    input  logic [1:0] r_cs,
    input  logic [7:0] r_dq_o,
    input  logic [7:0] r_dq_oe,
    output logic [7:0] r_dq_i,
    output logic       pad_sck,
    output logic       pad_cs,
    output logic [3:0] pad_dq_o,
    output logic [3:0] pad_dq_oe,
    input  logic [3:0] pad_dq_i
);

    logic [2:0] base;
    assign base = {owner, 2'b00};

    always_comb begin
        pad_sck   = SCK_IDLE;
        pad_cs    = CS_IDLE;
        pad_dq_o  = '0;
        pad_dq_oe = DQ_OE_IDLE;
        r_dq_i    = '0;
        if (valid) begin
            pad_sck            = r_sck[owner];
            pad_cs             = r_cs[owner];
            pad_dq_o           = r_dq_o[base +: 4];
            pad_dq_oe          = r_dq_oe[base +: 4];
            r_dq_i[base +: 4]  = pad_dq_i;
        end
    end

endmodule

// File: rtl/qspi_pin_arbiter.sv
// Round-robin owner of the shared QSPI pin set with a forced idle turnaround.
// Optional idle-hold revocation is enabled by defining QSPI_ARB_TIMEOUT_EN.
module qspi_pin_arbiter
    import qspi_arb_pkg::*;
#(
    parameter int unsigned TURN_CYCLES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    input  logic [1:0] r_sck,
    input  logic [1:0] r_cs,
    input  logic [7:0] r_dq_o,
    input  logic [7:0] r_dq_oe,
    output logic [7:0] r_dq_i,
    output logic       pad_sck,
    output logic       pad_cs,
    output logic [3:0] pad_dq_o,
    output logic [3:0] pad_dq_oe,
    input  logic [3:0] pad_dq_i,
    output logic       abort
);

    if (TURN_CYCLES < 1 || TURN_CYCLES > 15) begin : g_bad_turn
        $error("TURN_CYCLES out of range 1..15");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 2..65535");
    end

    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);

    arb_state_t state_q, state_d;
    logic       rr_ptr_q, rr_ptr_d;
    logic [3:0] turn_cnt_q, turn_cnt_d;
    logic [1:0] gnt_q;
    logic       abort_q, abort_d;
    owner_t     owner;
    logic       own_valid;
    logic       revoke;

    assign owner     = (state_q == OWN1);
    assign own_valid = (state_q == OWN0) || (state_q == OWN1);

`ifdef QSPI_ARB_TIMEOUT_EN
    // Counts only while the owner sits deselected and the other side waits.
    logic [15:0] to_cnt_q;
    logic        hold_idle;

    assign hold_idle = own_valid && r_cs[owner] && req[~owner];
    assign revoke    = hold_idle && (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) to_cnt_q <= '0;
        else       to_cnt_q <= hold_idle ? to_cnt_q + 16'd1 : '0;
    end
`else
    assign revoke = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        turn_cnt_d = turn_cnt_q;
        abort_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req == 2'b01 || (req == 2'b11 && !rr_ptr_q)) begin
                    state_d  = OWN0;
                    rr_ptr_d = 1'b1;
                end else if (req == 2'b10 || (req == 2'b11 && rr_ptr_q)) begin
                    state_d  = OWN1;
                    rr_ptr_d = 1'b0;
                end
            end
            OWN0, OWN1: begin
                if (!req[owner]) begin
                    state_d    = TURN;
                    turn_cnt_d = TURN_LOAD;
                    abort_d    = !r_cs[owner];
                end else if (revoke) begin
                    state_d    = TURN;
                    turn_cnt_d = TURN_LOAD;
                end
            end
            TURN: begin
                if (turn_cnt_q == '0) state_d = IDLE;
                else                  turn_cnt_d = turn_cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 1'b0;
            turn_cnt_q <= '0;
            gnt_q      <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            turn_cnt_q <= turn_cnt_d;
            gnt_q      <= {state_d == OWN1, state_d == OWN0};
            abort_q    <= abort_d;
        end
    end

    assign gnt   = gnt_q;
    assign abort = abort_q;

    qspi_pin_mux u_mux (
        .owner     (owner),
        .valid     (own_valid),
        .r_sck     (r_sck),
        .r_cs      (r_cs),
        .r_dq_o    (r_dq_o),
        .r_dq_oe   (r_dq_oe),
        .r_dq_i    (r_dq_i),
        .pad_sck   (pad_sck),
        .pad_cs    (pad_cs),
        .pad_dq_o  (pad_dq_o),
        .pad_dq_oe (pad_dq_oe),
        .pad_dq_i  (pad_dq_i)
    );

endmodule

// File: tb/tb_qspi_pin_arbiter.sv
// Directed self-checking bench for qspi_pin_arbiter (TURN_CYCLES=2, TIMEOUT_CYCLES=8).
module tb_qspi_pin_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req = '0;
    logic [1:0] gnt;
    logic [1:0] r_sck = '0;
    logic [1:0] r_cs = 2'b11;
    logic [7:0] r_dq_o = '0;
    logic [7:0] r_dq_oe = '0;
    logic [7:0] r_dq_i;
    logic       pad_sck;
    logic       pad_cs;
    logic [3:0] pad_dq_o;
    logic [3:0] pad_dq_oe;
    logic [3:0] pad_dq_i = '0;
    logic       abort;

    int errors = 0;
    int checks = 0;

    qspi_pin_arbiter #(.TURN_CYCLES(2), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset), .req(req), .gnt(gnt),
        .r_sck(r_sck), .r_cs(r_cs), .r_dq_o(r_dq_o), .r_dq_oe(r_dq_oe),
        .r_dq_i(r_dq_i), .pad_sck(pad_sck), .pad_cs(pad_cs),
        .pad_dq_o(pad_dq_o), .pad_dq_oe(pad_dq_oe), .pad_dq_i(pad_dq_i),
        .abort(abort)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic apply_reset();
        req = '0; r_sck = '0; r_cs = 2'b11; r_dq_o = '0; r_dq_oe = '0; pad_dq_i = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        checks++;
        if (gnt !== 2'b00 || abort !== 1'b0) begin
            errors++; $display("FAIL reset_gnt_abort: gnt=%b abort=%b expected 00/0", gnt, abort);
        end
        checks++;
        if ({pad_cs, pad_sck, pad_dq_o, pad_dq_oe} !== 10'b10_0000_0000) begin
            errors++; $display("FAIL reset_pads: cs=%b sck=%b o=%h oe=%h expected 1 0 0 0",
                               pad_cs, pad_sck, pad_dq_o, pad_dq_oe);
        end
        checks++;
        if (r_dq_i !== 8'h00) begin
            errors++; $display("FAIL reset_r_dq_i: got %h expected 00", r_dq_i);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_grant();
        apply_reset();
        req = 2'b01;
        tick();
        checks++;
        if (gnt !== 2'b01) begin
            errors++; $display("FAIL single_gnt: got %b expected 01", gnt);
        end
        r_cs = 2'b10; r_sck = 2'b01; r_dq_o = 8'h35; r_dq_oe = 8'h0F; pad_dq_i = 4'hA;
        #1;
        checks++;
        if ({pad_cs, pad_sck, pad_dq_o, pad_dq_oe} !== {1'b0, 1'b1, 4'h5, 4'hF}) begin
            errors++; $display("FAIL single_pads: cs=%b sck=%b o=%h oe=%h expected 0 1 5 f",
                               pad_cs, pad_sck, pad_dq_o, pad_dq_oe);
        end
        checks++;
        if (r_dq_i !== 8'h0A) begin
            errors++; $display("FAIL single_r_dq_i: got %h expected 0a", r_dq_i);
        end
        r_cs = 2'b11;
        req = 2'b00;
        tick();
        checks++;
        if (gnt !== 2'b00 || pad_dq_oe !== 4'h0 || pad_cs !== 1'b1 || abort !== 1'b0) begin
            errors++; $display("FAIL release_edge: gnt=%b oe=%h cs=%b abort=%b expected 00 0 1 0",
                               gnt, pad_dq_oe, pad_cs, abort);
        end
        req = 2'b01;
        tick();
        checks++;
        if (gnt !== 2'b00 || pad_dq_oe !== 4'h0 || r_dq_i !== 8'h00) begin
            errors++; $display("FAIL turn_second: gnt=%b oe=%h r_dq_i=%h expected 00 0 00",
                               gnt, pad_dq_oe, r_dq_i);
        end
        tick();
        checks++;
        if (gnt !== 2'b00) begin
            errors++; $display("FAIL idle_third: gnt=%b expected 00", gnt);
        end
        tick();
        checks++;
        if (gnt !== 2'b01) begin
            errors++; $display("FAIL regrant_after_turn: gnt=%b expected 01", gnt);
        end
        req = 2'b00;
        r_dq_oe = '0;
    endtask

    task automatic test_contention();
        apply_reset();
        req = 2'b11;
        tick();
        checks++;
        if (gnt !== 2'b01) begin
            errors++; $display("FAIL contend_first: gnt=%b expected 01", gnt);
        end
        tick();
        tick();
        checks++;
        if (gnt !== 2'b01) begin
            errors++; $display("FAIL contend_hold: gnt=%b expected 01", gnt);
        end
        req = 2'b10;
        tick();
        checks++;
        if (gnt !== 2'b00) begin
            errors++; $display("FAIL contend_release: gnt=%b expected 00", gnt);
        end
        tick();
        tick();
        checks++;
        if (gnt !== 2'b00) begin
            errors++; $display("FAIL contend_wait: gnt=%b expected 00", gnt);
        end
        tick();
        checks++;
        if (gnt !== 2'b10) begin
            errors++; $display("FAIL contend_second: gnt=%b expected 10", gnt);
        end
        req = 2'b11;
        tick();
        req = 2'b01;
        tick();
        req = 2'b11;
        tick();
        tick();
        tick();
        checks++;
        if (gnt !== 2'b01) begin
            errors++; $display("FAIL contend_rr_back: gnt=%b expected 01", gnt);
        end
        req = 2'b00;
    endtask

    task automatic test_abort();
        apply_reset();
        req = 2'b01;
        tick();
        r_cs = 2'b10;
        req = 2'b11;
        tick();
        checks++;
        if (gnt !== 2'b01 || pad_cs !== 1'b0 || abort !== 1'b0) begin
            errors++; $display("FAIL abort_pre: gnt=%b cs=%b abort=%b expected 01 0 0", gnt, pad_cs, abort);
        end
        req = 2'b10;
        tick();
        checks++;
        if (abort !== 1'b1 || pad_cs !== 1'b1 || gnt !== 2'b00) begin
            errors++; $display("FAIL abort_pulse: abort=%b cs=%b gnt=%b expected 1 1 00", abort, pad_cs, gnt);
        end
        tick();
        checks++;
        if (abort !== 1'b0) begin
            errors++; $display("FAIL abort_width: abort=%b expected 0", abort);
        end
        tick();
        tick();
        checks++;
        if (gnt !== 2'b10) begin
            errors++; $display("FAIL abort_next_owner: gnt=%b expected 10", gnt);
        end
        req = 2'b00;
        r_cs = 2'b11;
    endtask

    task automatic test_async_reset();
        apply_reset();
        req = 2'b10;
        tick();
        r_dq_oe = 8'hF0;
        r_cs = 2'b01;
        #1;
        checks++;
        if (pad_dq_oe !== 4'hF || pad_cs !== 1'b0) begin
            errors++; $display("FAIL own1_pads: oe=%h cs=%b expected f 0", pad_dq_oe, pad_cs);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (pad_dq_oe !== 4'h0 || pad_cs !== 1'b1 || gnt !== 2'b00) begin
            errors++; $display("FAIL async_reset: oe=%h cs=%b gnt=%b expected 0 1 00", pad_dq_oe, pad_cs, gnt);
        end
        reset = 1'b0;
        req = 2'b11;
        tick();
        checks++;
        if (gnt !== 2'b01) begin
            errors++; $display("FAIL post_reset_rr: gnt=%b expected 01", gnt);
        end
        req = 2'b00;
        r_dq_oe = '0;
        r_cs = 2'b11;
    endtask

`ifdef QSPI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        req = 2'b11;
        tick();
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (gnt !== 2'b01) begin
            errors++; $display("FAIL timeout_before: gnt=%b expected 01", gnt);
        end
        tick();
        checks++;
        if (gnt !== 2'b00 || abort !== 1'b0) begin
            errors++; $display("FAIL timeout_revoke: gnt=%b abort=%b expected 00 0", gnt, abort);
        end
        tick();
        tick();
        tick();
        checks++;
        if (gnt !== 2'b10) begin
            errors++; $display("FAIL timeout_next: gnt=%b expected 10", gnt);
        end
        r_cs = 2'b01;
        for (int i = 0; i < 12; i++) tick();
        checks++;
        if (gnt !== 2'b10) begin
            errors++; $display("FAIL timeout_cs_low_hold: gnt=%b expected 10", gnt);
        end
        req = 2'b00;
        r_cs = 2'b11;
    endtask
`endif

    initial begin
        test_reset();
        test_single_grant();
        test_contention();
        test_abort();
        test_async_reset();
`ifdef QSPI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
